// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared constants and state encodings for the fetch stage
package if_fetch_pkg;
  localparam logic Stop = 1'b1;
  localparam logic NoStop = 1'b0;
  localparam int InstAddrBus = 32;
  localparam int InstBus = 32;
  localparam logic [InstBus-1:0] ZeroWord = 32'h0000_0000;
  localparam logic [6:0] OPCODE_JAL = 7'b1101111;
  localparam logic [2:0] ST_B0 = 3'd0;
  localparam logic [2:0] ST_B1 = 3'd1;
  localparam logic [2:0] ST_B2 = 3'd2;
  localparam logic [2:0] ST_B3 = 3'd3;
  localparam logic [2:0] ST_READY = 3'd4;
  localparam logic [2:0] ST_ABORT = 3'd5;
  typedef enum logic [2:0] {
    B0 = ST_B0,
    B1 = ST_B1,
    B2 = ST_B2,
    B3 = ST_B3,
    READY = ST_READY,
    ABORT = ST_ABORT
  } state_t;
endpackage

// File: rtl/if_fetch_predecode.sv
// if_predecode: static JAL-taken prediction of the next fetch pc
module if_predecode
  import if_fetch_pkg::*;
(
  input  logic [InstAddrBus-1:0] pc,
  input  logic [InstBus-1:0]     inst,
  output logic [InstAddrBus-1:0] next_pc,
  output logic                   jump
);
  assign jump = inst[6:0] == OPCODE_JAL;
  assign next_pc = pc + (jump ? {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} : 32'd4);
endmodule

// File: rtl/if_fetch.sv
// if_fetch: byte-serial instruction fetch with JAL predecode and EX redirect
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             stall,
  input  logic                   redirect_i,
  input  logic [InstAddrBus-1:0] redirect_pc_i,
  input  logic                   mem_valid_i,
  input  logic [7:0]             mem_data_i,
  output logic                   mem_req_o,
  output logic [InstAddrBus-1:0] mem_addr_o,
  output logic                   get_inst,
  output logic [InstAddrBus-1:0] if_pc,
  output logic [InstBus-1:0]     if_inst,
  output logic                   jump
);
  state_t state, state_n;
  logic [InstAddrBus-1:0] pc, pc_n, npc_r, pd_npc;
  logic [InstBus-1:0] word;
  logic [23:0] buf_q;
  logic take, pd_jump, unused_stall;
  assign unused_stall = ^stall[5:1];
  assign take = mem_req_o && mem_valid_i;
  assign word = {mem_data_i, buf_q};
  if_predecode u_predecode (
    .pc(pc),
    .inst(word),
    .next_pc(pd_npc),
    .jump(pd_jump)
  );
  // next state and next pc; redirect overrides everything but reset
  always_comb begin
    state_n = redirect_i ? ABORT :
              state == ABORT ? B0 :
              state == READY ? (stall[0] == Stop ? READY : B0) :
              take ? (state == B3 ? READY : state_t'(state + 3'd1)) : state;
    pc_n = redirect_i ? redirect_pc_i : (state == READY && stall[0] == NoStop) ? npc_r : pc;
  end
  // registered state, byte buffer and all outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= B0;
      pc <= RESET_PC;
      npc_r <= ZeroWord;
      buf_q <= '0;
      mem_req_o <= 1'b0;
      mem_addr_o <= ZeroWord;
      get_inst <= 1'b0;
      if_pc <= ZeroWord;
      if_inst <= ZeroWord;
      jump <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      mem_req_o <= !state_n[2];
      if (!state_n[2]) mem_addr_o <= pc_n + {30'd0, state_n[1:0]};
      if (take && !redirect_i && state != B3) buf_q[{state[1:0], 3'b000} +: 8] <= mem_data_i;
      if (redirect_i) begin
        get_inst <= 1'b0;
        jump <= 1'b0;
      end else if (take && state == B3) begin
        get_inst <= 1'b1;
        if_inst <= word;
        if_pc <= pc;
        jump <= pd_jump;
        npc_r <= pd_npc;
      end else if (state == READY && stall[0] == NoStop) begin
        get_inst <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: randomized and directed checks of if_fetch against a transaction-level model
module tb_if_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] stall = '0;
  logic redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic mem_valid_i = 1'b0;
  logic [7:0] mem_data_i = '0;
  logic mem_req_o, get_inst, jump;
  logic [31:0] mem_addr_o, if_pc, if_inst;

  if_fetch #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .get_inst(get_inst),
    .if_pc(if_pc), .if_inst(if_inst), .jump(jump)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] img [logic [31:0]];
  logic [31:0] m_pc, m_next, m_ipc, m_inst;
  int m_n;
  bit m_rdy, m_hold, m_jump;

  function automatic logic [7:0] mem_b(input logic [31:0] a);
    logic [31:0] h;
    if (img.exists(a)) return img[a];
    h = a * 32'h9E37_79B1 + 32'h1234_5678;
    return h[23:16];
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {mem_b(a + 32'd3), mem_b(a + 32'd2), mem_b(a + 32'd1), mem_b(a)};
  endfunction

  function automatic logic [31:0] jal_target(input logic [31:0] a, input logic [31:0] w);
    int off;
    off = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096 - int'(w[31]) * 1048576;
    return a + 32'(off);
  endfunction

  task automatic put_word(input logic [31:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) img[a + 32'(k)] = w[8*k +: 8];
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    bit exp_req;
    exp_req = !(m_hold || m_rdy);
    chk("mem_req_o", {31'd0, mem_req_o}, {31'd0, exp_req});
    if (exp_req) chk("mem_addr_o", mem_addr_o, m_pc + 32'(m_n));
    chk("get_inst", {31'd0, get_inst}, {31'd0, m_rdy});
    if (m_rdy) begin
      chk("if_pc", if_pc, m_ipc);
      chk("if_inst", if_inst, m_inst);
      chk("jump", {31'd0, jump}, {31'd0, m_jump});
    end
  endtask

  task automatic model_update(input bit r, input bit rd, input logic [31:0] rpc, input bit st, input bit v);
    if (r) begin
      m_pc = 32'h0; m_n = 0; m_rdy = 0; m_hold = 1;
    end else if (rd) begin
      m_pc = rpc; m_n = 0; m_rdy = 0; m_hold = 1;
    end else if (m_hold) begin
      m_hold = 0;
    end else if (m_rdy) begin
      if (!st) begin
        m_rdy = 0; m_pc = m_next; m_n = 0;
      end
    end else if (v) begin
      m_n++;
      if (m_n == 4) begin
        m_rdy = 1;
        m_ipc = m_pc;
        m_inst = word_at(m_pc);
        m_jump = m_inst[6:0] == 7'h6F;
        m_next = m_jump ? jal_target(m_pc, m_inst) : m_pc + 32'd4;
      end
    end
  endtask

  task automatic step(input bit rd, input logic [31:0] rpc, input bit st, input int vm);
    bit v;
    compare();
    v = !(m_hold || m_rdy) && (vm == 0 || $urandom_range(0, 2) != 0);
    redirect_i = rd;
    redirect_pc_i = rpc;
    stall = {5'($urandom), st};
    mem_valid_i = v;
    mem_data_i = v ? mem_b(m_pc + 32'(m_n)) : 8'($urandom);
    @(posedge clk);
    model_update(rst, rd, rpc, st, v);
    @(negedge clk);
  endtask

  task automatic run_until_get();
    int n;
    n = 0;
    while (!get_inst && n < 40) begin
      step(0, 32'h0, 0, 0);
      n++;
    end
    chk("get_timeout", {31'd0, get_inst}, 32'd1);
  endtask

  initial begin
    int n;
    logic [31:0] w, t;
    m_pc = 0; m_n = 0; m_rdy = 0; m_hold = 1; m_next = 0; m_ipc = 0; m_inst = 0; m_jump = 0;
    put_word(32'h0, 32'h0050_0013);
    put_word(32'h10, 32'h0080_006F);
    put_word(32'h18, 32'h0000_0013);
    put_word(32'hFFFF_FFFC, 32'h0000_0013);
    for (int i = 0; i < 32; i++) begin
      w = $urandom;
      if (i % 2 == 0) w[6:0] = 7'h6F;
      else if (w[6:0] == 7'h6F) w[0] = 1'b0;
      put_word(32'h1000 + 32'(4 * i), w);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    step(0, 32'h0, 0, 0);
    chk("rst_mem_req_o", {31'd0, mem_req_o}, 32'd0);
    chk("rst_mem_addr_o", mem_addr_o, 32'd0);
    chk("rst_get_inst", {31'd0, get_inst}, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    chk("rst_jump", {31'd0, jump}, 32'd0);
    rst = 1'b0;
    n = 0;
    do begin
      step(0, 32'h0, 0, 0);
      n++;
    end while (!get_inst && n < 20);
    chk("first_latency", 32'(n), 32'd5);
    chk("first_if_inst", if_inst, 32'h0050_0013);
    chk("first_if_pc", if_pc, 32'h0);
    chk("first_jump", {31'd0, jump}, 32'd0);
    step(0, 32'h0, 0, 0);
    chk("seq_req", {31'd0, mem_req_o}, 32'd1);
    chk("seq_addr", mem_addr_o, 32'h4);
    step(1, 32'h10, 0, 0);
    run_until_get();
    chk("jal_inst", if_inst, 32'h0080_006F);
    chk("jal_jump", {31'd0, jump}, 32'd1);
    step(0, 32'h0, 0, 0);
    chk("jal_target_addr", mem_addr_o, 32'h18);
    run_until_get();
    for (int i = 0; i < 3; i++) begin
      step(0, 32'h0, 1, 0);
      chk("stall_get", {31'd0, get_inst}, 32'd1);
      chk("stall_if_pc", if_pc, 32'h18);
      chk("stall_req", {31'd0, mem_req_o}, 32'd0);
    end
    step(0, 32'h0, 0, 0);
    chk("unstall_addr", mem_addr_o, 32'h1C);
    step(0, 32'h0, 0, 0);
    step(0, 32'h0, 0, 0);
    step(1, 32'h40, 0, 0);
    chk("abort_req", {31'd0, mem_req_o}, 32'd0);
    step(0, 32'h0, 0, 0);
    chk("redir_req", {31'd0, mem_req_o}, 32'd1);
    chk("redir_addr", mem_addr_o, 32'h40);
    run_until_get();
    chk("redir_if_pc", if_pc, 32'h40);
    step(1, 32'h80, 0, 0);
    chk("ready_redir_get", {31'd0, get_inst}, 32'd0);
    chk("ready_redir_req", {31'd0, mem_req_o}, 32'd0);
    step(0, 32'h0, 0, 0);
    chk("ready_redir_addr", mem_addr_o, 32'h80);
    step(1, 32'hFFFF_FFFC, 0, 0);
    step(0, 32'h0, 0, 0);
    chk("wrap_first_addr", mem_addr_o, 32'hFFFF_FFFC);
    run_until_get();
    chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    step(0, 32'h0, 0, 0);
    chk("wrap_next_addr", mem_addr_o, 32'h0);
    for (int i = 0; i < 4000; i++) begin
      bit rd;
      rst = $urandom_range(0, 299) == 0;
      rd = $urandom_range(0, 39) == 0;
      t = $urandom_range(0, 1) == 1 ? 32'h1000 + 32'(4 * $urandom_range(0, 31)) : $urandom;
      step(rd, t, $urandom_range(0, 2) == 0, 1);
    end
    rst = 1'b0;
    step(0, 32'h0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the pipeline: holds the PC, fetches each 32-bit instruction as four little-endian bytes through the byte-wide memory-controller port, and presents it with its PC to the IF/ID register. It statically predicts JAL as taken, redirects on its own, and flags such instructions with `jump`. It accepts a redirect from EX on branch or jump resolution, and honours pipeline stall bit 0.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  6  pipeline stall vector; only bit 0 (IF stop, 1 = Stop) is used.
- redirect_i  in  1  EX redirect request; same cycle as the IF/ID flush.
- redirect_pc_i  in  32  new fetch PC when redirect_i = 1.
- mem_valid_i  in  1  memory controller returns the byte at mem_addr_o this cycle.
- mem_data_i  in  8  returned byte.
- mem_req_o  out  1  fetch request, held until the byte returns.
- mem_addr_o  out  32  byte address requested.
- get_inst  out  1  if_inst / if_pc valid for handoff.
- if_pc  out  32  PC of presented instruction.
- if_inst  out  32  presented instruction.
- jump  out  1  presented instruction was predicted taken (JAL).

## Operation
- States: B0, B1, B2, B3, READY, ABORT.
- Reset: pc = RESET_PC, state B0. Output reset values are mem_req_o 0, mem_addr_o 0, get_inst 0, if_pc 0, if_inst 0, jump 0.
- Bk (k = 0..3):
  - mem_req_o = 1, mem_addr_o = pc + k, using 32-bit modulo-2^32 add.
  - On mem_valid_i, capture mem_data_i into buffer bits [8k+7:8k] and advance to Bk+1.
  - B3 with valid goes to READY.
- Entering READY: if_inst = assembled word, if_pc = pc, get_inst = 1, mem_req_o = 0.
  - Predecode: if if_inst[6:0] = 7'b1101111 (JAL), next_pc = pc + sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}) and jump = 1.
  - Otherwise next_pc = pc + 4 and jump = 0.
- READY with stall[0] = NoStop: handoff occurs on this edge (IF/ID captures). pc <= next_pc, get_inst <= 0, state goes to B0.
- READY with stall[0] = Stop: all outputs hold.
- stall[0] does not pause the byte fetch in B0..B3. Fetch completes and waits in READY.
- redirect_i has priority over everything except rst, in any state:
  - pc <= redirect_pc_i; get_inst, jump and mem_req_o go to 0; the byte buffer is discarded; state goes to ABORT.
  - A mem_valid_i in the same cycle is ignored.
- ABORT: mem_req_o = 0 for exactly one cycle so the controller drops any in-flight request, then B0.
- redirect in READY in the same cycle as a handoff: the redirect wins internally. IF/ID discards the word via its own flush, which has priority there.
- redirect_pc_i[1:0] is used unmodified. Misalignment is not checked.

## Timing
- All outputs are registered.
- With mem_valid_i high in the cycle after each request, the minimum is 4 fetch cycles plus 1 READY cycle, i.e. 5 cycles per instruction.
- After a redirect: 1 ABORT cycle, then the first request for redirect_pc_i (mem_req_o = 1, mem_addr_o = redirect_pc_i) is visible in the following cycle.
- The predicted JAL target is fetched starting the cycle after handoff. There is no bubble beyond the normal B0 start.
- Reset mid-fetch: the next cycle shows reset values. Fetch of RESET_PC begins one cycle after rst deasserts.

## Structure
- Shared defines header holds:
  - constants: `Stop`/`NoStop`, `ZeroWord`, `InstAddrBus`/`InstBus`, and OPCODE_JAL = 7'b1101111;
  - the state encodings, as 3-bit localparams.
- One natural sub-module: if_predecode. It is combinational, takes pc and inst, and outputs next_pc and jump. It is reused later when branch prediction grows.

## Test plan
- Reset, memory returns bytes 13,00,50,00 at addresses 0..3 with 1-cycle latency -> get_inst = 1 with if_inst = 32'h00500013, if_pc = 0, jump = 0 on cycle 5; next request at address 4.
- Bytes of JAL x0,+8 (32'h0080006F) at pc 0x10 -> jump = 1; after handoff mem_addr_o = 0x18.
- stall[0] = 1 for 3 cycles while in READY -> outputs stable for 3 cycles; pc advances only on the first cycle with stall[0] = 0.
- redirect_i with redirect_pc_i = 0x40 during B2, with mem_valid_i high in the same cycle -> that byte is dropped, one cycle of mem_req_o = 0, then mem_addr_o = 0x40 and a fresh 4-byte fetch.
- redirect_i in READY in the same cycle as stall[0] = 0 -> pc = redirect target, not pc + 4; get_inst = 0 next cycle.
- pc = 0xFFFF_FFFC -> addresses FC, FD, FE, FF; next sequential fetch at 0x0000_0000.
